// File: rtl/jacobian_pkg.sv
// Shared types and constants for the Jacobian builder.
// Row indices, FSM states and multiplier lane map.
package jacobian_pkg;

    localparam int FIX_W = 27;
    typedef logic signed [FIX_W-1:0] fix_t;

    localparam int JV_X = 0;
    localparam int JV_Y = 1;
    localparam int JV_Z = 2;
    localparam int JW_X = 3;
    localparam int JW_Y = 4;
    localparam int JW_Z = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIFF,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_DONE
    } state_t;

    // Lane l multiplies axis[LANE_A[l]] by d[LANE_B[l]] (0=x,1=y,2=z)
    localparam logic [5:0][1:0] LANE_A = {2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd1};
    localparam logic [5:0][1:0] LANE_B = {2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

endpackage

// File: rtl/jacobian_sub3.sv
// Three-lane subtractor y = a - b.
// Saturates when JACOBIAN_SATURATE_EN is defined, wraps otherwise.
module jacobian_sub3
    import jacobian_pkg::*;
#(
    parameter int W = 27
) (
    input  logic [2:0][W-1:0] a,
    input  logic [2:0][W-1:0] b,
    output logic [2:0][W-1:0] y
);

`ifdef JACOBIAN_SATURATE_EN
    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic [2:0][W:0] wide;

    always_comb begin
        wide = '0;
        y    = '0;
        for (int i = 0; i < 3; i++) begin
            wide[i] = {a[i][W-1], a[i]} - {b[i][W-1], b[i]};
            if (wide[i][W] != wide[i][W-1])
                y[i] = wide[i][W] ? MINV : MAXV;
            else
                y[i] = wide[i][W-1:0];
        end
    end
`else
    always_comb begin
        y = '0;
        for (int i = 0; i < 3; i++)
            y[i] = a[i] - b[i];
    end
`endif

endmodule

// File: rtl/jacobian_builder.sv
// Builds a 6xNJ geometric Jacobian, one joint at a time, on a shared 6-lane multiplier.
// Build option: JACOBIAN_SATURATE_EN saturates the DIFF/WB subtractions.
module jacobian_builder
    import jacobian_pkg::*;
#(
    parameter int NJ       = 6,
    parameter int W        = 27,
    parameter int FRAC     = 16,
    parameter int MULT_LAT = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NJ-1:0]                joint_type,
    input  logic [NJ-1:0][2:0][W-1:0]    axis,
    input  logic [NJ-1:0][2:0][W-1:0]    origin,
    input  logic [2:0][W-1:0]            end_pos,
    output logic [5:0][W-1:0]            mult_dataa,
    output logic [5:0][W-1:0]            mult_datab,
    output logic                         mult_valid,
    input  logic [5:0][W-1:0]            mult_result,
    output logic [5:0][NJ-1:0][W-1:0]    jacobian_matrix,
    output logic                         busy,
    output logic                         done
);

    localparam int JW = (NJ > 1) ? $clog2(NJ) : 1;
    localparam logic [JW-1:0] LAST = JW'(NJ - 1);
    localparam logic [3:0] WAIT_INIT = 4'(MULT_LAT - 1);

    if (NJ < 1 || NJ > 8 || MULT_LAT < 1 || MULT_LAT > 15 ||
        FRAC < 1 || FRAC >= W) begin : g_bad_cfg
        $error("jacobian_builder: parameter out of range");
    end

    state_t                       state;
    logic [JW-1:0]                jidx;
    logic [3:0]                   wcnt;
    logic [NJ-1:0]                jt_q;
    logic [NJ-1:0][2:0][W-1:0]    axis_q;
    logic [NJ-1:0][2:0][W-1:0]    origin_q;
    logic [2:0][W-1:0]            pe_q;
    logic [5:0][W-1:0]            res_q;

    logic [2:0][W-1:0]            sub_a;
    logic [2:0][W-1:0]            sub_b;
    logic [2:0][W-1:0]            sub_y;
    logic [5:0][W-1:0]            lane_a;
    logic [5:0][W-1:0]            lane_b;
    logic                         start;

    // DONE can relaunch directly so a held en gives gapless runs
    always_comb begin
        start = en && (state == S_IDLE || state == S_DONE);
    end

    // One subtractor serves d = p_e - p_i (DIFF) and the cross-product terms (WB)
    always_comb begin
        sub_a = pe_q;
        sub_b = origin_q[jidx];
        if (state == S_WB) begin
            sub_a = {res_q[4], res_q[2], res_q[0]};
            sub_b = {res_q[5], res_q[3], res_q[1]};
        end
    end

    jacobian_sub3 #(
        .W (W)
    ) u_sub3 (
        .a (sub_a),
        .b (sub_b),
        .y (sub_y)
    );

    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int l = 0; l < 6; l++) begin
            lane_a[l] = axis_q[jidx][LANE_A[l]];
            lane_b[l] = sub_y[LANE_B[l]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            jidx            <= '0;
            wcnt            <= '0;
            jt_q            <= '0;
            axis_q          <= '0;
            origin_q        <= '0;
            pe_q            <= '0;
            res_q           <= '0;
            mult_dataa      <= '0;
            mult_datab      <= '0;
            mult_valid      <= 1'b0;
            jacobian_matrix <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                jt_q     <= joint_type;
                axis_q   <= axis;
                origin_q <= origin;
                pe_q     <= end_pos;
                jidx     <= '0;
            end
            unique case (state)
                S_IDLE: begin
                    if (en) begin
                        state <= S_DIFF;
                        busy  <= 1'b1;
                    end
                end
                S_DIFF: begin
                    mult_dataa <= lane_a;
                    mult_datab <= lane_b;
                    mult_valid <= jt_q[jidx];
                    state      <= S_ISSUE;
                end
                S_ISSUE: begin
                    mult_valid <= 1'b0;
                    wcnt       <= WAIT_INIT;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // Counts WAIT_INIT down to 0; product lands on the final edge
                    if (wcnt == 4'd0) begin
                        res_q <= mult_result;
                        state <= S_WB;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                S_WB: begin
                    if (jt_q[jidx]) begin
                        jacobian_matrix[JV_X][jidx] <= sub_y[0];
                        jacobian_matrix[JV_Y][jidx] <= sub_y[1];
                        jacobian_matrix[JV_Z][jidx] <= sub_y[2];
                        jacobian_matrix[JW_X][jidx] <= axis_q[jidx][0];
                        jacobian_matrix[JW_Y][jidx] <= axis_q[jidx][1];
                        jacobian_matrix[JW_Z][jidx] <= axis_q[jidx][2];
                    end else begin
                        jacobian_matrix[JV_X][jidx] <= axis_q[jidx][0];
                        jacobian_matrix[JV_Y][jidx] <= axis_q[jidx][1];
                        jacobian_matrix[JV_Z][jidx] <= axis_q[jidx][2];
                        jacobian_matrix[JW_X][jidx] <= '0;
                        jacobian_matrix[JW_Y][jidx] <= '0;
                        jacobian_matrix[JW_Z][jidx] <= '0;
                    end
                    if (jidx == LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        jidx  <= jidx + 1'b1;
                        state <= S_DIFF;
                    end
                end
                S_DONE: begin
                    state <= en ? S_DIFF : S_IDLE;
                    busy  <= en;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jacobian_builder.sv
// Directed bench for jacobian_builder: default instance plus an NJ=3, MULT_LAT=1 instance.
// Each instance is paired with an ideal pipelined multiplier.
module tb_jacobian_builder;
    import jacobian_pkg::*;

    localparam int W    = 27;
    localparam int FRAC = 16;
    localparam int NJ   = 6;
    localparam int ML   = 5;
    localparam int NJS  = 3;
    localparam int MLS  = 1;
    localparam int CW   = 6 * W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                        en_a;
    logic [NJ-1:0]               jt_a;
    logic [NJ-1:0][2:0][W-1:0]   ax_a, or_a;
    logic [2:0][W-1:0]           pe_a;
    logic [5:0][W-1:0]           da_a, db_a, mr_a;
    logic                        mv_a;
    logic [5:0][NJ-1:0][W-1:0]   jm_a;
    logic                        busy_a, done_a;

    logic                        en_s;
    logic [NJS-1:0]              jt_s;
    logic [NJS-1:0][2:0][W-1:0]  ax_s, or_s;
    logic [2:0][W-1:0]           pe_s;
    logic [5:0][W-1:0]           da_s, db_s, mr_s;
    logic                        mv_s;
    logic [5:0][NJS-1:0][W-1:0]  jm_s;
    logic                        busy_s, done_s;

    jacobian_builder dut (
        .clk (clk), .rst (rst), .en (en_a),
        .joint_type (jt_a), .axis (ax_a), .origin (or_a), .end_pos (pe_a),
        .mult_dataa (da_a), .mult_datab (db_a), .mult_valid (mv_a),
        .mult_result (mr_a), .jacobian_matrix (jm_a),
        .busy (busy_a), .done (done_a)
    );

    jacobian_builder #(.NJ(NJS), .W(W), .FRAC(FRAC), .MULT_LAT(MLS)) dut_s (
        .clk (clk), .rst (rst), .en (en_s),
        .joint_type (jt_s), .axis (ax_s), .origin (or_s), .end_pos (pe_s),
        .mult_dataa (da_s), .mult_datab (db_s), .mult_valid (mv_s),
        .mult_result (mr_s), .jacobian_matrix (jm_s),
        .busy (busy_s), .done (done_s)
    );

    function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        return p[FRAC+W-1:FRAC];
    endfunction

    logic [5:0][W-1:0] pipe_a [ML];
    logic [5:0][W-1:0] pipe_s [MLS];

    always @(posedge clk) begin
        for (int l = 0; l < 6; l++) pipe_a[0][l] <= fmul(da_a[l], db_a[l]);
        for (int k = 1; k < ML; k++) pipe_a[k] <= pipe_a[k-1];
    end
    always @(posedge clk) begin
        for (int l = 0; l < 6; l++) pipe_s[0][l] <= fmul(da_s[l], db_s[l]);
    end
    assign mr_a = pipe_a[ML-1];
    assign mr_s = pipe_s[MLS-1];

    typedef struct packed {
        logic              jt;
        logic [2:0][W-1:0] z;
        logic [2:0][W-1:0] p;
        logic [CW-1:0]     e;
    } vec_t;

    vec_t tv [NJ];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [CW-1:0] pk6(input int r0, r1, r2, r3, r4, r5);
        return {W'(r0), W'(r1), W'(r2), W'(r3), W'(r4), W'(r5)};
    endfunction

    function automatic logic [2:0][W-1:0] v3(input int x, y, z);
        return {W'(z), W'(y), W'(x)};
    endfunction

    function automatic logic [CW-1:0] col_a(input int j);
        logic [CW-1:0] c;
        c = '0;
        for (int r = 0; r < 6; r++) c[(5-r)*W +: W] = jm_a[r][j];
        return c;
    endfunction

    function automatic logic [CW-1:0] col_s(input int j);
        logic [CW-1:0] c;
        c = '0;
        for (int r = 0; r < 6; r++) c[(5-r)*W +: W] = jm_s[r][j];
        return c;
    endfunction

    task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic t, input logic [2:0][W-1:0] z,
                           input logic [2:0][W-1:0] p, input logic [CW-1:0] e);
        tv[i].jt = t;
        tv[i].z  = z;
        tv[i].p  = p;
        tv[i].e  = e;
    endtask

    task automatic load_a();
        for (int j = 0; j < NJ; j++) begin
            jt_a[j] = tv[j].jt;
            ax_a[j] = tv[j].z;
            or_a[j] = tv[j].p;
        end
        pe_a = v3(131072, 65536, 32768);
    endtask

    task automatic kick(input bit s);
        @(negedge clk);
        if (s) en_s = 1'b1;
        else   en_a = 1'b1;
        @(posedge clk);
        #1;
        en_s = 1'b0;
        en_a = 1'b0;
    endtask

    task automatic run_wait(input bit s, input int budget, input int poke,
                            output int dcyc, output logic [63:0] vm,
                            output logic [W-1:0] db2);
        dcyc = 0;
        vm   = '0;
        db2  = '0;
        for (int n = 1; n <= budget && dcyc == 0; n++) begin
            @(negedge clk);
            if (n == poke) begin
                for (int j = 0; j < NJ; j++) ax_a[j] = v3(65536, 0, 0);
                en_a = 1'b1;
            end
            if (n == poke + 1) en_a = 1'b0;
            if ((s ? mv_s : mv_a) && n < 64) vm[n] = 1'b1;
            if (s && n == 2) db2 = db_s[2];
            if (s ? done_s : done_a) dcyc = n;
        end
        if (dcyc == 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout budget=%0d", budget);
        end
    endtask

    int              dc, d1, d2, nd;
    logic [63:0]     vm;
    logic [W-1:0]    db2;
    logic [W-1:0]    dx;
    logic [CW-1:0]   ec;

    initial begin
        en_a = 1'b0; jt_a = '0; ax_a = '0; or_a = '0; pe_a = '0;
        en_s = 1'b0; jt_s = '0; ax_s = '0; or_s = '0; pe_s = '0;

        set_vec(0, 1'b1, v3(0, 0, 65536), v3(0, 0, 0),
                pk6(-65536, 131072, 0, 0, 0, 65536));
        set_vec(1, 1'b1, v3(65536, 0, 0), v3(65536, 0, 0),
                pk6(0, -32768, 65536, 65536, 0, 0));
        set_vec(2, 1'b0, v3(65536, 0, 0), v3(12345, -7, 99),
                pk6(65536, 0, 0, 0, 0, 0));
        set_vec(3, 1'b1, v3(0, 65536, 0), v3(0, 0, -65536),
                pk6(98304, 0, -131072, 0, 65536, 0));
        set_vec(4, 1'b0, v3(0, 0, -65536), v3(65536, 65536, 65536),
                pk6(0, 0, -65536, 0, 0, 0));
        set_vec(5, 1'b1, v3(0, -65536, 0), v3(65536, 65536, 65536),
                pk6(32768, 0, 65536, 0, -65536, 0));

        repeat (3) @(negedge clk);
        chk("rst_matrix", CW'(|jm_a), '0);
        chk("rst_ctl", CW'({busy_a, done_a, mv_a}), '0);
        chk("rst_lanes", CW'(|{da_a, db_a}), '0);
        rst = 1'b1;

        // Mixed revolute/prismatic table
        load_a();
        kick(1'b0);
        run_wait(1'b0, 120, -1, dc, vm, db2);
        chk("tbl_done_cycle", CW'(dc), CW'(49));
        chk("tbl_valid_cycles", CW'(vm),
            CW'((64'd1 << 2) | (64'd1 << 10) | (64'd1 << 26) | (64'd1 << 42)));
        @(negedge clk);
        chk("tbl_done_pulse", CW'({done_a, busy_a}), '0);
        for (int j = 0; j < NJ; j++)
            chk($sformatf("tbl_col%0d", j), col_a(j), tv[j].e);

        // Uniform z-axis run; inputs change and en pulses mid-run
        jt_a = '1;
        for (int j = 0; j < NJ; j++) begin
            ax_a[j] = v3(0, 0, 65536);
            or_a[j] = v3(0, 0, 0);
        end
        pe_a = v3(65536, 0, 0);
        kick(1'b0);
        run_wait(1'b0, 120, 10, dc, vm, db2);
        chk("uni_done_cycle", CW'(dc), CW'(49));
        ec = pk6(0, 65536, 0, 0, 0, 65536);
        for (int j = 0; j < NJ; j++)
            chk($sformatf("uni_col%0d", j), col_a(j), ec);

        // en held high: back-to-back runs on the poked x-axis inputs
        @(negedge clk);
        en_a = 1'b1;
        @(posedge clk);
        d1 = 0;
        d2 = 0;
        for (int n = 1; n <= 150 && d2 == 0; n++) begin
            @(negedge clk);
            if (done_a) begin
                if (d1 == 0) d1 = n;
                else begin
                    d2 = n;
                    en_a = 1'b0;
                end
            end
        end
        chk("held_done1", CW'(d1), CW'(49));
        chk("held_done2", CW'(d2), CW'(98));
        @(negedge clk);
        chk("held_idle", CW'(busy_a), '0);
        chk("held_col0", col_a(0), pk6(0, 0, 0, 65536, 0, 0));
        chk("held_col5", col_a(5), pk6(0, 0, 0, 65536, 0, 0));

        // Reset during WAIT of joint 3
        load_a();
        kick(1'b0);
        repeat (29) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_matrix", CW'(|jm_a), '0);
        chk("mid_rst_ctl", CW'({busy_a, done_a, mv_a}), '0);
        chk("mid_rst_lanes", CW'(|{da_a, db_a}), '0);
        @(negedge clk);
        rst = 1'b1;
        nd = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done_a) nd++;
        end
        chk("mid_rst_no_done", CW'(nd), '0);
        kick(1'b0);
        run_wait(1'b0, 120, -1, dc, vm, db2);
        chk("rerun_done_cycle", CW'(dc), CW'(49));
        chk("rerun_col2", col_a(2), tv[2].e);
        chk("rerun_col3", col_a(3), tv[3].e);

        // NJ=3, MULT_LAT=1 instance with a p_e x at the positive limit
`ifdef JACOBIAN_SATURATE_EN
        dx = W'(67108863);
`else
        dx = W'(-67043329);
`endif
        jt_s = 3'b011;
        pe_s = v3(67108863, 0, 0);
        ax_s[0] = v3(0, 0, 65536);
        or_s[0] = v3(-65536, 0, 0);
        ax_s[1] = v3(0, 0, 65536);
        or_s[1] = v3(0, 0, 0);
        ax_s[2] = v3(0, 65536, 0);
        or_s[2] = v3(0, 0, 0);
        kick(1'b1);
        run_wait(1'b1, 40, -1, dc, vm, db2);
        chk("s_done_cycle", CW'(dc), CW'(13));
        chk("s_valid_cycles", CW'(vm), CW'((64'd1 << 2) | (64'd1 << 6)));
        chk("s_diff_x", CW'(db2), CW'(dx));
        chk("s_col0", col_s(0), {W'(0), dx, W'(0), W'(0), W'(0), W'(65536)});
        chk("s_col1", col_s(1), pk6(0, 67108863, 0, 0, 0, 65536));
        chk("s_col2", col_s(2), pk6(0, 65536, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
